// File: rtl/axi_read_master.sv
// AXI4 read master serving single-word instruction fetches.
// Optional 4-word line buffer is enabled by defining the macro BURST4_EN;
// without it every fetch is a single-beat read of the requested word.
module axi_read_master #(
  parameter logic [3:0] MASTER_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_core_req,
  input  logic [31:0] i_core_addr,
  input  logic        i_core_flush,
  output logic        o_core_stall,
  output logic [31:0] o_core_rdata,
  output logic        o_core_valid,
  output logic        o_core_err,
  output logic [3:0]  o_arid,
  output logic [31:0] o_araddr,
  output logic [3:0]  o_arlen,
  output logic [2:0]  o_arsize,
  output logic [1:0]  o_arburst,
  output logic        o_arvalid,
  input  logic        i_arready,
  input  logic [3:0]  i_rid,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  input  logic        i_rlast,
  input  logic        i_rvalid,
  output logic        o_rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t      r_state;
  logic [31:0] r_araddr;
  logic [3:0]  r_arlen;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_core_valid;
  logic        r_core_err;
  logic [31:0] r_core_rdata;
  logic [1:0]  r_beat;
  logic        r_err;

  logic        w_hit;
  logic        w_miss;
  logic        w_beat;
  logic        w_rerr;
  logic        w_capture;
  logic [31:0] w_hit_word;
  logic [31:0] w_req_addr;
  logic [3:0]  w_req_len;

  assign w_beat = (r_state == DATA) && r_rready && i_rvalid;
  assign w_rerr = (i_rresp != 2'b00);
  assign w_miss = (r_state == IDLE) && i_core_req && !w_hit;

`ifdef BURST4_EN
  logic [27:0] r_tag;
  logic [31:0] r_line [4];
  logic        r_line_valid;
  logic        r_flushed;
  logic [1:0]  r_word;

  // A flush in the request cycle wins over a tag match.
  assign w_hit      = r_line_valid && (r_tag == i_core_addr[31:4]) && !i_core_flush;
  assign w_hit_word = r_line[i_core_addr[3:2]];
  assign w_capture  = (r_beat == r_word);
  assign w_req_addr = {i_core_addr[31:4], 4'b0000};
  assign w_req_len  = 4'd3;

  // Line valid bookkeeping: invalid while filling, flush-sensitive at any time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_line_valid <= 1'b0;
      r_flushed    <= 1'b0;
      r_word       <= 2'd0;
    end else begin
      if (w_miss) begin
        r_line_valid <= 1'b0;
        r_flushed    <= 1'b0;
        r_word       <= i_core_addr[3:2];
      end
      if (w_beat && i_rlast)
        r_line_valid <= !(r_err || w_rerr) && !r_flushed;
      // Later assignment wins, so a flush always leaves the line invalid.
      if (i_core_flush) begin
        r_line_valid <= 1'b0;
        if (r_state != IDLE)
          r_flushed <= 1'b1;
      end
    end
  end

  // Line storage and tag fill.
  // NOTE: storage and tag are not reset; r_line_valid alone guards their contents.
  always_ff @(posedge clk) begin
    if (w_miss)
      r_tag <= i_core_addr[31:4];
    if (w_beat)
      r_line[r_beat] <= i_rdata;
  end
`else
  assign w_hit      = 1'b0;
  assign w_hit_word = 32'd0;
  assign w_capture  = 1'b1;
  assign w_req_addr = {i_core_addr[31:2], 2'b00};
  assign w_req_len  = 4'd0;
`endif

  // Byte-offset bits, RID and (in some builds) the flush input carry no meaning here.
  wire w_unused = &{1'b0, i_rid, i_core_addr[1:0], i_core_flush};

  // Main fetch FSM with registered AXI and core-response outputs.
  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_araddr     <= 32'd0;
      r_arlen      <= 4'd0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_core_valid <= 1'b0;
      r_core_err   <= 1'b0;
      r_core_rdata <= 32'd0;
      r_beat       <= 2'd0;
      r_err        <= 1'b0;
    end else begin
      r_core_valid <= 1'b0;
      r_core_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_core_req && w_hit) begin
            r_core_valid <= 1'b1;
            r_core_rdata <= w_hit_word;
          end else if (w_miss) begin
            r_state   <= ADDR;
            r_araddr  <= w_req_addr;
            r_arlen   <= w_req_len;
            r_arvalid <= 1'b1;
            r_err     <= 1'b0;
            r_beat    <= 2'd0;
          end
        end
        ADDR: begin
          if (i_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (w_beat) begin
            r_beat <= r_beat + 2'd1;
            if (w_rerr)
              r_err <= 1'b1;
            if (w_capture)
              r_core_rdata <= i_rdata;
            if (i_rlast) begin
              r_rready     <= 1'b0;
              r_core_valid <= 1'b1;
              r_core_err   <= r_err || w_rerr;
              r_state      <= RESP;
            end
          end
        end
        RESP: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stall rises combinationally on a miss in IDLE so the core holds its address.
  assign o_core_stall = !rst && ((r_state != IDLE) || w_miss);

  assign o_core_rdata = r_core_rdata;
  assign o_core_valid = r_core_valid;
  assign o_core_err   = r_core_err;
  assign o_arid       = MASTER_ID;
  assign o_araddr     = r_araddr;
  assign o_arlen      = r_arlen;
  assign o_arsize     = 3'b010;
  assign o_arburst    = 2'b01;
  assign o_arvalid    = r_arvalid;
  assign o_rready     = r_rready;

endmodule
